// File: rtl/calc_pkg.sv
`default_nettype none
// =============================================================================
// calc_pkg : shared types and constants for the calculator sequencer
// Revision : 1.0
// =============================================================================
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_MUL  = 3'd5,
        OP_DIV  = 3'd6,
        OP_RSVD = 3'd7
    } calc_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } calc_state_t;

    // Build-time switch for the iterative divider (CALC_DIV_EN).
    function automatic logic div_enabled();
`ifdef CALC_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_if.sv
`default_nettype none
// =============================================================================
// calc_if : operand-entry handshake and result bus of the calculator sequencer
// Revision : 1.0
// =============================================================================
interface calc_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             res_valid;
    logic             err;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, res_lo, res_hi, res_valid, err, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, res_lo, res_hi, res_valid, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/calc_muldiv.sv
`default_nettype none
// =============================================================================
// calc_muldiv : iterative shift-add multiplier / restoring divider, one bit
//               per enabled cycle. Divider present only with CALC_DIV_EN.
// Revision    : 1.0
// =============================================================================
module calc_muldiv
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             load;
    logic [WIDTH:0]   mul_sum;

`ifdef CALC_DIV_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   div_shift;

    assign load = start;
`else
    // Without the divider a divide request must never start the engine.
    assign load = start && !is_div;
`endif

    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
`ifdef CALC_DIV_EN
        is_div_d  = is_div_q;
        div_shift = {hi_q, lo_q[WIDTH-1]};
`endif
        if (ena) begin
            done_d = 1'b0;
            if (load) begin
                lo_d  = a;
                hi_d  = '0;
                b_d   = b;
                cnt_d = CW'(WIDTH);
`ifdef CALC_DIV_EN
                is_div_d = is_div;
`endif
            end else if (cnt_q != '0) begin
                cnt_d  = cnt_q - CW'(1);
                done_d = (cnt_q == CW'(1));
`ifdef CALC_DIV_EN
                if (is_div_q) begin
                    // Remainder lives in hi, quotient shifts into lo.
                    if (div_shift >= {1'b0, b_q}) begin
                        hi_d = div_shift[WIDTH-1:0] - b_q;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q     <= '0;
            hi_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef CALC_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef CALC_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// =============================================================================
// calc_sequencer : operand/opcode entry FSM, single-cycle ALU and result
//                  registers. Divide support selected by CALC_DIV_EN.
// Revision       : 1.0
// =============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  ena,
    calc_if.slave bus
);
    calc_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    calc_op_t         op_q, op_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;

    logic             din_ready;
    logic             xfer;
    calc_op_t         din_op;
    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_lo, eng_hi;
    logic [WIDTH-1:0] alu_lo, alu_hi;
    logic             alu_err;
    logic [WIDTH:0]   add_full, sub_full;

    // Division by zero never enters the engine; it resolves on the ALU path.
    function automatic logic needs_engine(calc_op_t op, logic [WIDTH-1:0] divisor);
        return (op == OP_MUL) || (div_enabled() && op == OP_DIV && divisor != '0);
    endfunction

    assign din_ready = ena && (state_q != ST_EXEC);
    assign xfer      = bus.din_valid && din_ready;
    assign din_op    = calc_op_t'(bus.din[2:0]);
    assign eng_start = xfer && (state_q == ST_GET_OP) && needs_engine(din_op, b_q);

    calc_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (eng_start),
        .is_div (din_op == OP_DIV),
        .a      (a_q),
        .b      (b_q),
        .done   (eng_done),
        .lo     (eng_lo),
        .hi     (eng_hi)
    );

    always_comb begin
        add_full = {1'b0, a_q} + {1'b0, b_q};
        sub_full = {1'b0, a_q} - {1'b0, b_q};
        alu_lo   = '0;
        alu_hi   = '0;
        alu_err  = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_lo = add_full[WIDTH-1:0];
                alu_hi = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
            end
            OP_SUB: begin
                alu_lo = sub_full[WIDTH-1:0];
                alu_hi = {{(WIDTH-1){1'b0}}, sub_full[WIDTH]};
            end
            OP_AND: alu_lo = a_q & b_q;
            OP_OR:  alu_lo = a_q | b_q;
            OP_XOR: alu_lo = a_q ^ b_q;
            OP_MUL: alu_lo = '0;
`ifdef CALC_DIV_EN
            OP_DIV: begin
                alu_err = 1'b1;
                alu_lo  = '1;
                alu_hi  = a_q;
            end
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    a_d     = bus.din;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (xfer) begin
                    b_d     = bus.din;
                    state_d = ST_GET_OP;
                end
            end
            ST_GET_OP: begin
                if (xfer) begin
                    op_d    = din_op;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ena) begin
                    if (needs_engine(op_q, b_q)) begin
                        if (eng_done) begin
                            res_lo_d    = eng_lo;
                            res_hi_d    = eng_hi;
                            err_d       = 1'b0;
                            res_valid_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end else begin
                        res_lo_d    = alu_lo;
                        res_hi_d    = alu_hi;
                        err_d       = alu_err;
                        res_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Result words stay visible until the next result overwrites them.
                if (xfer) begin
                    a_d         = bus.din;
                    res_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_GET_B;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.res_lo    = res_lo_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q == ST_EXEC);

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Operand-entry and execution controller for the TinyTapeout calculator top level. It collects operand A, operand B and an opcode over a shared 8-bit input bus using a valid/ready handshake, and sequences either a single-cycle ALU operation or an iterative multiply/divide engine. It holds the result until the next entry begins. It sits between the `ui_in`/`uio_in` pin decode and the `uo_out`/`uio_out` result mux inside `tt_um_randyzhu_calc`.

## Interface
- `WIDTH`, default 8: operand width; the iteration count equals `WIDTH`.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable; when low, the FSM and iteration counter freeze.
- `din` in WIDTH: operand or opcode byte; opcode uses `din[2:0]`.
- `din_valid` in 1: `din` holds a valid byte.
- `din_ready` out 1: the block can accept a byte this cycle.
- `res_lo` out WIDTH: result low word.
- `res_hi` out WIDTH: result high word (carry, borrow, product high word or remainder).
- `res_valid` out 1: result registers are valid.
- `err` out 1: reserved opcode or divide by zero.
- `busy` out 1: the block is in EXEC.

## Operation
- States: IDLE, GET_B, GET_OP, EXEC, DONE.
- Transfer: a byte is accepted when `din_valid && din_ready` at a rising edge.
- `din_ready` equals `ena` while in IDLE, GET_B, GET_OP or DONE, and 0 in EXEC.
- IDLE: on transfer, capture A and go to GET_B.
- GET_B: on transfer, capture B and go to GET_OP.
- GET_OP: on transfer, capture the opcode and go to EXEC.
- DONE: on transfer, capture the new A, clear `res_valid` and `err`, and go to GET_B. `res_lo`/`res_hi` keep their values until the next result is written.
- Opcodes:
  - 0 ADD: lo = A+B, hi = {0, carry}.
  - 1 SUB: lo = A−B, hi = {0, borrow}.
  - 2 AND, 3 OR, 4 XOR: hi = 0.
  - 5 MUL: {hi, lo} = A×B, unsigned.
  - 6 DIV: lo = A/B, hi = A%B, unsigned.
  - 7 reserved: err = 1, lo = hi = 0.
- Divide by zero: err = 1, lo = all-ones, hi = A. No iterations run; the result takes the ALU-path latency.
- Opcodes 0–4 and 7 complete in one EXEC cycle.
- MUL uses shift-add and DIV uses restoring division, one bit per cycle for WIDTH cycles, followed by one latch cycle.
- A `din_valid` during EXEC is ignored (not consumed).
- `ena` low in any state: no transfer, no iteration, and no state change. All outputs hold.

## Timing
- Reset, asynchronous: state = IDLE; `res_lo` = `res_hi` = 0; `res_valid` = `err` = `busy` = 0. Captured A, B and opcode are cleared, and the iteration counter = 0.
- Reset asserted mid-EXEC aborts the operation immediately. After deassertion the block is in IDLE.
- Latency is measured from the opcode-transfer edge N:
  - ALU path: `busy` is high for the cycle after N. Result, `err` and `res_valid` are registered at edge N+1.
  - MUL/DIV: iterations occur at edges N+1..N+WIDTH. The result is latched, `res_valid` set and `busy` cleared at edge N+WIDTH+1 (N+9 for WIDTH = 8).
- `ena` low cycles extend each latency by exactly their count.
- Back-to-back operation: A can be transferred in the first cycle of DONE. `res_valid` falls at that same edge.

## Configuration
- `CALC_DIV_EN`:
  - Defined: opcode 6 performs division, and the divider is built inside `calc_muldiv`.
  - Undefined: the divider logic is absent and opcode 6 behaves exactly like opcode 7 (err = 1, lo = hi = 0, ALU latency).

## Structure
- Package `calc_pkg` holds:
  - opcode enum `calc_op_t` (3 bits, values above);
  - state enum `calc_state_t`;
  - localparam `CALC_WIDTH` = 8.
- Sub-module `calc_muldiv`: iterative engine.
  - Ports: `clk`, `rst_n`, `ena`, `start`, `is_div`, `a`, `b`, `done`, `lo`, `hi`.
  - `start` is a one-cycle pulse from the controller.
  - `done` is a one-cycle pulse at the final iteration edge.
- `calc_sequencer` owns the FSM, the operand registers, the single-cycle ALU and the result registers.

## Test plan
- ADD: A = 0xC8, B = 0x64, op 0 → lo = 0x2C, hi = 0x01, `res_valid` one edge after the op transfer, `err` = 0.
- SUB: A = 0x10, B = 0x20, op 1 → lo = 0xF0, hi = 0x01.
- MUL: A = 0xFF, B = 0xFF, op 5 → hi = 0xFE, lo = 0x01, `res_valid` exactly 9 edges after the op transfer, `busy` high for 9 cycles.
- DIV (with `CALC_DIV_EN`):
  - 200 / 7 → lo = 0x1C, hi = 0x04.
  - 0x55 / 0 → `err` = 1, lo = 0xFF, hi = 0x55.
  - Without the macro: op 6 → `err` = 1, lo = hi = 0.
- Stall/abort:
  - Hold `ena` low for 3 cycles mid-MUL → `res_valid` 12 edges after the op transfer.
  - `din_valid` during EXEC → not consumed.
  - `rst_n` pulse mid-DIV → all outputs 0, state IDLE, next entry works.
- Back-to-back: new A sent in the first DONE cycle → `res_valid` drops at that edge; the second result is correct.
